// File: rtl/merger_lane_buffer_pkg.sv
// rtl/merger_lane_buffer_pkg.sv - shared defaults for the merger lane buffer
package merger_lane_buffer_pkg;

   localparam int DEF_RADIX      = 4;
   localparam int DEF_COORD_BITS = 8;
   localparam int DEF_LANE_DEPTH = 4;

   // Reserved all-ones coordinate shown on a lane with nothing to offer.
   function automatic logic [DEF_COORD_BITS-1:0] coord_sentinel();
      return '1;
   endfunction

endpackage

// File: rtl/merger_lane_buffer_lane_fifo.sv
// rtl/merger_lane_buffer_lane_fifo.sv - single-lane circular FIFO with flush
module merger_lane_buffer_lane_fifo #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)
            count <= count + 1'b1;
         else if (pop && !push)
            count <= count - 1'b1;
      end
   end

   // Storage is not reset; the top never exposes an entry unless the lane is non-empty.
   always_ff @(posedge clock) begin
      if (push && !flush)
         mem[wr_ptr] <= din;
   end

   assign full  = (count == FULL_COUNT);
   assign empty = (count == '0);
   assign head  = mem[rd_ptr];

endmodule

// File: rtl/merger_lane_buffer.sv
// rtl/merger_lane_buffer.sv - per-lane input buffering and merge gating ahead of the coordinate merger
module merger_lane_buffer
   import merger_lane_buffer_pkg::*;
#(
   parameter int MERGER_RADIX      = DEF_RADIX,
   parameter int MERGER_COORD_BITS = DEF_COORD_BITS,
   parameter int LANE_DEPTH        = DEF_LANE_DEPTH
) (
   input  logic                                   clock,
   input  logic                                   reset,
   input  logic                                   start,
   input  logic [MERGER_RADIX-1:0]                in_valid,
   input  logic [MERGER_RADIX*MERGER_COORD_BITS-1:0] in_coord,
   input  logic [MERGER_RADIX-1:0]                in_last,
   output logic [MERGER_RADIX-1:0]                in_ready,
   input  logic [MERGER_RADIX-1:0]                fetch_next,
   output logic [MERGER_RADIX*MERGER_COORD_BITS-1:0] coord_in,
   output logic [MERGER_RADIX-1:0]                lane_valid,
   output logic [MERGER_RADIX-1:0]                lane_done,
   output logic                                   merge_ok,
   output logic                                   all_done
);

   localparam int R  = MERGER_RADIX;
   localparam int CB = MERGER_COORD_BITS;
   localparam logic [CB-1:0] SENTINEL = '1;

   logic [R-1:0] done;
   logic [R-1:0] full;
   logic [R-1:0] empty;
   logic [R-1:0] push;
   logic [R-1:0] pop;
   logic [R-1:0] head_last;
   logic [CB:0]  head [R];

   assign in_ready   = ~full & ~done & {R{~start}};
   assign push       = in_valid & in_ready;
   assign lane_valid = ~empty & ~done;
   assign lane_done  = done;
   assign all_done   = &done;
   assign merge_ok   = (&(lane_valid | done)) & ~all_done;
   // Pops are only honoured while every lane can be compared, keeping merger output ordered.
   assign pop        = fetch_next & lane_valid & {R{merge_ok}};

   for (genvar i = 0; i < R; i++) begin : g_lane
      merger_lane_buffer_lane_fifo #(
         .WIDTH (CB + 1),
         .DEPTH (LANE_DEPTH)
      ) u_fifo (
         .clock (clock),
         .reset (reset),
         .flush (start),
         .push  (push[i]),
         .pop   (pop[i]),
         .din   ({in_last[i], in_coord[i*CB +: CB]}),
         .full  (full[i]),
         .empty (empty[i]),
         .head  (head[i])
      );

      assign head_last[i]         = head[i][CB];
      assign coord_in[i*CB +: CB] = lane_valid[i] ? head[i][CB-1:0] : SENTINEL;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         done <= '0;
      else if (start)
         done <= '0;
      else
         done <= done | (pop & head_last);
   end

endmodule

// File: tb/tb_merger_lane_buffer.sv
// tb/tb_merger_lane_buffer.sv - self-checking bench for merger_lane_buffer
module tb_merger_lane_buffer;

   logic        clock;
   logic        reset;
   logic        start;
   logic [3:0]  in_valid;
   logic [31:0] in_coord;
   logic [3:0]  in_last;
   logic [3:0]  in_ready;
   logic [3:0]  fetch_next;
   logic [31:0] coord_in;
   logic [3:0]  lane_valid;
   logic [3:0]  lane_done;
   logic        merge_ok;
   logic        all_done;

   merger_lane_buffer #(
      .MERGER_RADIX      (4),
      .MERGER_COORD_BITS (8),
      .LANE_DEPTH        (4)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .start      (start),
      .in_valid   (in_valid),
      .in_coord   (in_coord),
      .in_last    (in_last),
      .in_ready   (in_ready),
      .fetch_next (fetch_next),
      .coord_in   (coord_in),
      .lane_valid (lane_valid),
      .lane_done  (lane_done),
      .merge_ok   (merge_ok),
      .all_done   (all_done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic        st;
      logic [3:0]  v;
      logic [31:0] c;
      logic [3:0]  l;
      logic [3:0]  f;
      logic [3:0]  rdy;
      logic [3:0]  lv;
      logic [3:0]  ld;
      logic        mok;
      logic        ad;
      logic [31:0] co;
   } vec_t;

   vec_t         tbl[$];
   logic [8:0]   q[4][$];
   logic [3:0]   done_m;
   int           n_checks;
   int           n_fail;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic st, input logic [3:0] v, input logic [31:0] c, input logic [3:0] l,
                      input logic [3:0] f, input logic [3:0] rdy, input logic [3:0] lv,
                      input logic [3:0] ld, input logic mok, input logic ad, input logic [31:0] co);
      vec_t e;
      e = '{st, v, c, l, f, rdy, lv, ld, mok, ad, co};
      tbl.push_back(e);
   endtask

   task automatic idle_inputs();
      start = 0; in_valid = 0; in_coord = 0; in_last = 0; fetch_next = 0;
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_in_ready"},   {28'd0, in_ready},   32'hF);
      chk({tag, "_lane_valid"}, {28'd0, lane_valid}, 32'h0);
      chk({tag, "_lane_done"},  {28'd0, lane_done},  32'h0);
      chk({tag, "_merge_ok"},   {31'd0, merge_ok},   32'h0);
      chk({tag, "_all_done"},   {31'd0, all_done},   32'h0);
      chk({tag, "_coord_in"},   coord_in,            32'hFFFFFFFF);
   endtask

   function automatic void model_out(output logic [3:0] lv, output logic mok, output logic [3:0] rdy);
      for (int i = 0; i < 4; i++) begin
         lv[i]  = (q[i].size() != 0) && !done_m[i];
         rdy[i] = (q[i].size() < 4) && !done_m[i];
      end
      mok = (&(lv | done_m)) && !(&done_m);
   endfunction

   // Scoreboarded cycle: predicted pops are compared against the queued pushes.
   task automatic step(input logic [3:0] v, input logic [31:0] c, input logic [3:0] l, input logic [3:0] f);
      logic [3:0] lv_m, rdy_m;
      logic       mok_m;
      logic [8:0] e;
      model_out(lv_m, mok_m, rdy_m);
      in_valid = v; in_coord = c; in_last = l; fetch_next = f;
      #1;
      for (int i = 0; i < 4; i++) begin
         if (f[i] && lv_m[i] && mok_m) begin
            e = q[i].pop_front();
            chk($sformatf("pop_lane%0d", i), {24'd0, coord_in[i*8 +: 8]}, {24'd0, e[7:0]});
            if (e[8]) done_m[i] = 1'b1;
         end
      end
      for (int i = 0; i < 4; i++)
         if (v[i] && rdy_m[i]) q[i].push_back({l[i], c[i*8 +: 8]});
      @(posedge clock);
      #1 idle_inputs();
      #1;
      model_out(lv_m, mok_m, rdy_m);
      chk("sb_in_ready",   {28'd0, in_ready},   {28'd0, rdy_m});
      chk("sb_lane_valid", {28'd0, lane_valid}, {28'd0, lv_m});
      chk("sb_lane_done",  {28'd0, lane_done},  {28'd0, done_m});
      chk("sb_merge_ok",   {31'd0, merge_ok},   {31'd0, mok_m});
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      done_m   = '0;
      idle_inputs();
      reset = 0;
      repeat (3) @(posedge clock);
      #1 chk_reset_state("in_reset");
      reset = 1;

      //   st  v     coord         last  fetch  rdy   lv    ld    mok ad  coord_in
      add(0, 4'h0, 32'h00000000, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 0, 0, 32'hFFFFFFFF);
      add(0, 4'hF, 32'h05040203, 4'h0, 4'h0, 4'hF, 4'hF, 4'h0, 1, 0, 32'h05040203);
      add(0, 4'h0, 32'h00000000, 4'h0, 4'h2, 4'hF, 4'hD, 4'h0, 0, 0, 32'h0504FF03);
      add(0, 4'h0, 32'h00000000, 4'h0, 4'h1, 4'hF, 4'hD, 4'h0, 0, 0, 32'h0504FF03);
      add(0, 4'h2, 32'h00000600, 4'h0, 4'h0, 4'hF, 4'hF, 4'h0, 1, 0, 32'h05040603);
      add(0, 4'h0, 32'h00000000, 4'h0, 4'h4, 4'hF, 4'hB, 4'h0, 0, 0, 32'h05FF0603);
      add(0, 4'h4, 32'h00070000, 4'h4, 4'h0, 4'hF, 4'hF, 4'h0, 1, 0, 32'h05070603);
      add(0, 4'h0, 32'h00000000, 4'h0, 4'h4, 4'hB, 4'hB, 4'h4, 1, 0, 32'h05FF0603);
      add(0, 4'h4, 32'h00090000, 4'h0, 4'h0, 4'hB, 4'hB, 4'h4, 1, 0, 32'h05FF0603);
      add(0, 4'h0, 32'h00000000, 4'h0, 4'h1, 4'hB, 4'hA, 4'h4, 0, 0, 32'h05FF06FF);
      add(0, 4'hB, 32'h23002120, 4'hB, 4'h0, 4'hB, 4'hB, 4'h4, 1, 0, 32'h05FF0620);
      add(0, 4'h0, 32'h00000000, 4'h0, 4'h1, 4'hA, 4'hA, 4'h5, 1, 0, 32'h05FF06FF);
      add(0, 4'h0, 32'h00000000, 4'h0, 4'h2, 4'hA, 4'hA, 4'h5, 1, 0, 32'h05FF21FF);
      add(0, 4'h0, 32'h00000000, 4'h0, 4'h2, 4'h8, 4'h8, 4'h7, 1, 0, 32'h05FFFFFF);
      add(0, 4'h0, 32'h00000000, 4'h0, 4'h8, 4'h8, 4'h8, 4'h7, 1, 0, 32'h23FFFFFF);
      add(0, 4'h0, 32'h00000000, 4'h0, 4'h8, 4'h0, 4'h0, 4'hF, 0, 1, 32'hFFFFFFFF);
      add(0, 4'h0, 32'h00000000, 4'h0, 4'h8, 4'h0, 4'h0, 4'hF, 0, 1, 32'hFFFFFFFF);
      add(1, 4'h0, 32'h00000000, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 0, 0, 32'hFFFFFFFF);
      add(1, 4'h1, 32'h00000044, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 0, 0, 32'hFFFFFFFF);

      for (int k = 0; k < tbl.size(); k++) begin
         start = tbl[k].st; in_valid = tbl[k].v; in_coord = tbl[k].c;
         in_last = tbl[k].l; fetch_next = tbl[k].f;
         @(posedge clock);
         #1 idle_inputs();
         #1;
         chk($sformatf("row%0d_in_ready", k),   {28'd0, in_ready},   {28'd0, tbl[k].rdy});
         chk($sformatf("row%0d_lane_valid", k), {28'd0, lane_valid}, {28'd0, tbl[k].lv});
         chk($sformatf("row%0d_lane_done", k),  {28'd0, lane_done},  {28'd0, tbl[k].ld});
         chk($sformatf("row%0d_merge_ok", k),   {31'd0, merge_ok},   {31'd0, tbl[k].mok});
         chk($sformatf("row%0d_all_done", k),   {31'd0, all_done},   {31'd0, tbl[k].ad});
         chk($sformatf("row%0d_coord_in", k),   coord_in,            tbl[k].co);
      end

      // Fill lane0, then push+pop against a full lane and wrap the pointers.
      step(4'hF, {8'd1, 8'd1, 8'd1, 8'd10}, 4'h0, 4'h0);
      for (int k = 11; k <= 13; k++) step(4'h1, {24'd0, 8'(k)}, 4'h0, 4'h0);
      chk("lane0_full_ready", {31'd0, in_ready[0]}, 32'h0);
      step(4'h1, {24'd0, 8'd99}, 4'h0, 4'h1);
      for (int k = 14; k <= 19; k++) step(4'h1, {24'd0, 8'(k)}, 4'h0, 4'h1);
      for (int k = 0; k < 4; k++) step(4'h0, 32'h0, 4'h0, 4'h1);
      chk("lane0_drained", {31'd0, lane_valid[0]}, 32'h0);

      // Half-full lanes with lane1 done, then asynchronous reset between edges.
      step(4'h3, {8'h00, 8'h00, 8'h31, 8'h30}, 4'h2, 4'h0);
      step(4'h1, {24'd0, 8'h32}, 4'h0, 4'h2);
      step(4'h0, 32'h0, 4'h0, 4'h2);
      chk("pre_reset_lane_done", {28'd0, lane_done}, 32'h2);
      #2 reset = 0;
      #1 chk_reset_state("async_reset");
      for (int i = 0; i < 4; i++) q[i].delete();
      done_m = '0;
      @(negedge clock);
      reset = 1;
      @(posedge clock);
      #2 chk_reset_state("post_reset");
      step(4'h1, {24'd0, 8'h55}, 4'h1, 4'h0);
      chk("post_reset_coord", coord_in, 32'hFFFFFF55);

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

endmodule
